// File: rtl/pe_svc_pkg.sv
// Shared types and sizes for the 64-requester priority-encoder grant sequencer.
package pe_svc_pkg;

  localparam int unsigned N_REQ = 64;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ISSUE
  } state_t;

  // True when exactly one bit of v is set.
  function automatic logic is_single(input logic [N_REQ-1:0] v);
    return (v != '0) && ((v & (v - N_REQ'(1))) == '0);
  endfunction

endpackage

// File: rtl/pe64_grant_seq_if.sv
// Load and grant handshakes of the grant sequencer.
interface pe64_grant_seq_if;

  logic                              load_valid;
  logic                              load_ready;
  logic [pe_svc_pkg::N_REQ-1:0]      load_vec;
  logic                              grant_valid;
  logic                              grant_ready;
  logic [pe_svc_pkg::IDX_W-1:0]      grant_idx;
  logic                              grant_last;

  modport slave (
    input  load_valid, load_vec, grant_ready,
    output load_ready, grant_valid, grant_idx, grant_last
  );

  modport master (
    output load_valid, load_vec, grant_ready,
    input  load_ready, grant_valid, grant_idx, grant_last
  );

endinterface

// File: rtl/onehot2bin64.sv
// Combinational one-hot to binary converter with zero and multi-hot detection.
module onehot2bin64
  import pe_svc_pkg::*;
(
  input  logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             zero,
  output logic             multi
);

  // OR of set-bit positions; only meaningful when the input is truly one-hot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
  end

  assign zero  = (onehot == '0);
  assign multi = ((onehot & (onehot - N_REQ'(1))) != '0);

endmodule

// File: rtl/pe64_grant_seq.sv
// Sequences grants for a 64-bit request vector through an external priority
// encoder with PE_LAT cycles of settle latency.
module pe64_grant_seq
  import pe_svc_pkg::*;
#(
  parameter int unsigned PE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  pe64_grant_seq_if.slave   bus,
  output logic [N_REQ-1:0]  pe_req,
  input  logic [N_REQ-1:0]  pe_onehot,
  output logic              busy,
  output logic              err_onehot
);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       enc_idx;
  logic                   enc_zero;
  logic                   enc_multi;
  logic                   enc_bad;
  logic [N_REQ-1:0]       clr_mask;
  logic [N_REQ-1:0]       pend_clr;

  onehot2bin64 u_conv (
    .onehot (pe_onehot),
    .idx    (enc_idx),
    .zero   (enc_zero),
    .multi  (enc_multi)
  );

  // The encoder answer must name exactly one still-pending requester.
  assign enc_bad = enc_zero | enc_multi | ((pe_onehot & ~pe_req) != '0);

  always_comb begin
    clr_mask = '0;
    clr_mask[bus.grant_idx] = 1'b1;
  end

  assign pend_clr = pe_req & ~clr_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pe_req          <= '0;
      cnt             <= '0;
      bus.grant_idx   <= '0;
      err_onehot      <= 1'b0;
      bus.load_ready  <= 1'b1;
      busy            <= 1'b0;
      bus.grant_valid <= 1'b0;
      bus.grant_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // An all-zero vector is accepted and dropped without leaving IDLE.
          if (bus.load_valid && (bus.load_vec != '0)) begin
            pe_req         <= bus.load_vec;
            cnt            <= CNT_W'(PE_LAT);
            state          <= SETTLE;
            bus.load_ready <= 1'b0;
            busy           <= 1'b1;
            bus.grant_last <= is_single(bus.load_vec);
          end
        end
        SETTLE: begin
          if (cnt <= CNT_W'(1)) begin
            cnt <= '0;
            if (enc_bad) begin
              err_onehot     <= 1'b1;
              pe_req         <= '0;
              state          <= IDLE;
              bus.load_ready <= 1'b1;
              busy           <= 1'b0;
              bus.grant_last <= 1'b0;
            end else begin
              bus.grant_idx   <= enc_idx;
              bus.grant_valid <= 1'b1;
              state           <= ISSUE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ISSUE: begin
          if (bus.grant_ready) begin
            bus.grant_valid <= 1'b0;
            pe_req          <= pend_clr;
            bus.grant_last  <= is_single(pend_clr);
            if (pend_clr == '0) begin
              state          <= IDLE;
              bus.load_ready <= 1'b1;
              busy           <= 1'b0;
            end else begin
              state <= SETTLE;
              cnt   <= CNT_W'(PE_LAT);
            end
          end
        end
        default: begin
          state           <= IDLE;
          pe_req          <= '0;
          bus.load_ready  <= 1'b1;
          busy            <= 1'b0;
          bus.grant_valid <= 1'b0;
          bus.grant_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe64_grant_seq.sv
// Randomized self-checking bench for pe64_grant_seq with a highest-bit-wins
// encoder model and a per-vector expected grant list.
module tb_pe64_grant_seq;

  localparam int unsigned PE_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pe_req;
  logic [63:0] pe_onehot;
  logic        busy;
  logic        err_onehot;
  logic        force_en;
  logic [63:0] force_val;

  int n_cmp = 0;
  int n_err = 0;

  pe64_grant_seq_if bus ();

  pe64_grant_seq #(.PE_LAT(PE_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .pe_req     (pe_req),
    .pe_onehot  (pe_onehot),
    .busy       (busy),
    .err_onehot (err_onehot)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] hibit(input logic [63:0] v);
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) return 64'(1) << i;
    end
    return '0;
  endfunction

  // Encoder model: highest set bit wins, settles within one cycle.
  assign pe_onehot = force_en ? force_val : hibit(pe_req);

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"},  64'(bus.load_ready),  64'd1);
    check({tag, "_grant_valid"}, 64'(bus.grant_valid), 64'd0);
    check({tag, "_grant_last"},  64'(bus.grant_last),  64'd0);
    check({tag, "_busy"},        64'(busy),            64'd0);
    check({tag, "_pe_req"},      pe_req,               64'd0);
    check({tag, "_grant_idx"},   64'(bus.grant_idx),   64'd0);
    check({tag, "_err"},         64'(err_onehot),      64'd0);
  endtask

  task automatic do_load(input logic [63:0] vec);
    @(negedge clk);
    check("load_ready_idle", 64'(bus.load_ready), 64'd1);
    bus.load_valid = 1'b1;
    bus.load_vec   = vec;
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    bus.load_vec   = {$urandom, $urandom};
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.grant_valid && n < 20);
  endtask

  // Loads vec and consumes every grant, checking order, timing and stability.
  task automatic service(input logic [63:0] vec, input bit hold_ready,
                         input int first_stall, input int max_stall, input bit junk_loads);
    logic [63:0] pend;
    int          n;
    int          k;
    bit          first;
    pend  = vec;
    first = 1'b1;
    bus.grant_ready = hold_ready;
    do_load(vec);
    if (vec == '0) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("zero_busy",  64'(busy),            64'd0);
        check("zero_valid", 64'(bus.grant_valid), 64'd0);
      end
      check("zero_ready", 64'(bus.load_ready), 64'd1);
      return;
    end
    if (junk_loads) bus.load_valid = 1'b1;
    for (int i = 63; i >= 0; i--) begin
      if (vec[i]) begin
        wait_grant(n);
        check("latency",  64'(n),             64'(PE_LAT + 1));
        check("idx",      64'(bus.grant_idx), 64'(i));
        check("last",     64'(bus.grant_last), 64'($countones(pend) == 1));
        check("pe_req",   pe_req,             pend);
        check("busy_run", 64'(busy),          64'd1);
        check("ld_rdy_run", 64'(bus.load_ready), 64'd0);
        k = hold_ready ? 0 : (first ? first_stall : $urandom_range(0, max_stall));
        first = 1'b0;
        for (int j = 0; j < k; j++) begin
          @(negedge clk);
          check("stall_valid", 64'(bus.grant_valid), 64'd1);
          check("stall_idx",   64'(bus.grant_idx),   64'(i));
          check("stall_last",  64'(bus.grant_last),  64'($countones(pend) == 1));
        end
        pend[i] = 1'b0;
        if (pend == '0) bus.load_valid = 1'b0;
        bus.grant_ready = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_ready) bus.grant_ready = 1'b0;
      end
    end
    bus.load_valid = 1'b0;
    @(negedge clk);
    check("end_busy",   64'(busy),            64'd0);
    check("end_ready",  64'(bus.load_ready),  64'd1);
    check("end_valid",  64'(bus.grant_valid), 64'd0);
    check("end_pe_req", pe_req,               64'd0);
    bus.grant_ready = 1'b0;
  endtask

  // Forces a bad encoder answer and expects a silent drop with err set.
  task automatic bad_encoder(input logic [63:0] vec, input logic [63:0] bad);
    force_en  = 1'b1;
    force_val = bad;
    do_load(vec);
    for (int c = 0; c < PE_LAT + 2; c++) begin
      @(negedge clk);
      check("err_no_grant", 64'(bus.grant_valid), 64'd0);
    end
    check("err_flag",   64'(err_onehot),     64'd1);
    check("err_pe_req", pe_req,              64'd0);
    check("err_busy",   64'(busy),           64'd0);
    check("err_ready",  64'(bus.load_ready), 64'd1);
    force_en = 1'b0;
  endtask

  initial begin
    logic [63:0] v;
    rst_n           = 1'b0;
    force_en        = 1'b0;
    force_val       = '0;
    bus.load_valid  = 1'b0;
    bus.load_vec    = '0;
    bus.grant_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    service(64'h8000_0000_0000_0001, 1'b1, 0, 0, 1'b0);
    service(64'h0000_0000_0000_00F0, 1'b0, 5, 0, 1'b0);
    service(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0, 1'b0);
    service(64'h0, 1'b0, 0, 0, 1'b0);

    bad_encoder(64'hFF, 64'h3);
    bad_encoder(64'hFF, 64'h0);
    bad_encoder(64'hFF, 64'h100);
    service(64'h0000_0100_0000_0022, 1'b0, 1, 2, 1'b0);
    check("err_sticky", 64'(err_onehot), 64'd1);

    for (int t = 0; t < 16; t++) begin
      case ($urandom_range(0, 3))
        0:       v = 64'(1) << $urandom_range(0, 63);
        1:       v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        2:       v = (t % 5 == 0) ? 64'h0 : {$urandom, $urandom};
        default: v = {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      service(v, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 3, 1'($urandom_range(0, 1)));
    end

    // Reset during ISSUE abandons the vector immediately.
    service(64'h0, 1'b0, 0, 0, 1'b0);
    bus.grant_ready = 1'b0;
    do_load(64'hFF);
    begin
      int n;
      wait_grant(n);
      check("pre_rst_valid", 64'(bus.grant_valid), 64'd1);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_issue");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during SETTLE.
    do_load(64'h0F00);
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_settle");
    @(negedge clk);
    rst_n = 1'b1;

    service(64'h0000_0000_8000_0003, 1'b1, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
